// File: rtl/jr_fwd_ctrl_if.sv
// jr_fwd_ctrl_if: ID-stage jr target hazard/forwarding signal bundle
interface jr_fwd_ctrl_if #(parameter int REG_AW = 5);
  logic              freeze;
  logic              id_is_jr;
  logic [REG_AW-1:0] id_rs;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_write_reg;
  logic              mem_reg_write;
  logic              mem_mem_read;
  logic [REG_AW-1:0] mem_write_reg;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_write_reg;
  logic [3:0]        fwd_sel;
  logic              stall;
  logic              bubble;
  modport master (
    output freeze, id_is_jr, id_rs, ex_reg_write, ex_mem_read, ex_write_reg,
           mem_reg_write, mem_mem_read, mem_write_reg, wb_reg_write, wb_write_reg,
    input  fwd_sel, stall, bubble
  );
  modport slave (
    input  freeze, id_is_jr, id_rs, ex_reg_write, ex_mem_read, ex_write_reg,
           mem_reg_write, mem_mem_read, mem_write_reg, wb_reg_write, wb_write_reg,
    output fwd_sel, stall, bubble
  );
endinterface

// File: rtl/jr_fwd_ctrl.sv
// jr_fwd_ctrl: jr/jalr target forwarding select and load-use stall FSM.
// Define JR_FWD_PERF_EN to build the stall_cnt performance counter.
module jr_fwd_ctrl #(
  parameter int REG_AW = 5
`ifdef JR_FWD_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input logic clk,
  input logic rst_n,
  jr_fwd_ctrl_if.slave bus
`ifdef JR_FWD_PERF_EN
  , output logic [PERF_W-1:0] stall_cnt
`endif
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_wcnt, w_wcnt_nx;
  logic [REG_AW-1:0] w_rs;
  logic [3:0] w_sel;
  logic w_vld, w_mex, w_mmem, w_mwb, w_hz_ex, w_hz_mem, w_stall;
  assign w_rs = bus.id_rs;
  assign w_vld = bus.id_is_jr & (|w_rs);
  assign w_mex = w_vld & bus.ex_reg_write & (bus.ex_write_reg == w_rs);
  assign w_mmem = w_vld & bus.mem_reg_write & (bus.mem_write_reg == w_rs);
  assign w_mwb = w_vld & bus.wb_reg_write & (bus.wb_write_reg == w_rs);
  // a non-load EX match supplies the youngest value, so it masks a MEM load
  assign w_hz_ex = w_mex & bus.ex_mem_read;
  assign w_hz_mem = ~w_mex & w_mmem & bus.mem_mem_read;
  always_comb begin
    w_next = r_state;
    w_wcnt_nx = r_wcnt;
    w_stall = 1'b0;
    w_sel = 4'b0001;
    if (r_state == IDLE) begin
      if (w_hz_ex | w_hz_mem) begin
        w_stall = 1'b1;
        w_wcnt_nx = w_hz_ex ? 2'd1 : 2'd0;
        w_next = w_hz_ex ? WAIT : IDLE;
      end else
        w_sel = w_mex ? 4'b0010 : w_mmem ? 4'b0100 : w_mwb ? 4'b1000 : 4'b0001;
    end else if (!bus.id_is_jr) begin
      w_next = IDLE;
      w_wcnt_nx = 2'd0;
    end else begin
      w_stall = 1'b1;
      w_wcnt_nx = (r_wcnt == 2'd0) ? 2'd0 : r_wcnt - 2'd1;
      w_next = (r_wcnt > 2'd1) ? WAIT : IDLE;
    end
  end
  assign bus.fwd_sel = rst_n ? w_sel : 4'b0001;
  assign bus.stall = rst_n & w_stall;
  assign bus.bubble = rst_n & w_stall & ~bus.freeze;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wcnt <= 2'd0;
    end else if (!bus.freeze) begin
      r_state <= w_next;
      r_wcnt <= w_wcnt_nx;
    end
  end
`ifdef JR_FWD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (!bus.freeze && w_stall) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_jr_fwd_ctrl.sv
// tb_jr_fwd_ctrl: vector table, corner sequences and randomized model check
module tb_jr_fwd_ctrl;
  typedef struct {
    logic jr; logic [4:0] rs;
    logic exw; logic exl; logic [4:0] exd;
    logic mw; logic ml; logic [4:0] md;
    logic ww; logic [4:0] wd; logic fz;
    logic [3:0] sel; logic st; logic bb;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  int m_rem;
  logic [31:0] m_cnt;
  vec_t tbl[12];
  vec_t v, z;
  jr_fwd_ctrl_if #(.REG_AW(5)) bus();
`ifdef JR_FWD_PERF_EN
  logic [31:0] stall_cnt;
  jr_fwd_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stall_cnt(stall_cnt));
`else
  jr_fwd_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input logic [31:0] exp);
`ifdef JR_FWD_PERF_EN
    chk(nm, stall_cnt, exp);
`endif
  endtask

  function automatic vec_t mk(input logic jr, input logic [4:0] rs,
      input logic exw, input logic exl, input logic [4:0] exd,
      input logic mw, input logic ml, input logic [4:0] md,
      input logic ww, input logic [4:0] wd, input logic fz,
      input logic [3:0] sel, input logic st, input logic bb);
    vec_t r;
    r.jr = jr; r.rs = rs; r.exw = exw; r.exl = exl; r.exd = exd;
    r.mw = mw; r.ml = ml; r.md = md; r.ww = ww; r.wd = wd; r.fz = fz;
    r.sel = sel; r.st = st; r.bb = bb;
    return r;
  endfunction

  task automatic apply(input vec_t a);
    bus.id_is_jr = a.jr; bus.id_rs = a.rs;
    bus.ex_reg_write = a.exw; bus.ex_mem_read = a.exl; bus.ex_write_reg = a.exd;
    bus.mem_reg_write = a.mw; bus.mem_mem_read = a.ml; bus.mem_write_reg = a.md;
    bus.wb_reg_write = a.ww; bus.wb_write_reg = a.wd; bus.freeze = a.fz;
  endtask

  task automatic rst_pulse();
    apply(z);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic cyc(input vec_t a);
    @(posedge clk);
    #1 apply(a);
    @(negedge clk);
  endtask

  task automatic outs(input string nm, input logic [3:0] sel, input logic st, input logic bb);
    chk({nm, ".sel"}, {28'd0, bus.fwd_sel}, {28'd0, sel});
    chk({nm, ".stall"}, {31'd0, bus.stall}, {31'd0, st});
    chk({nm, ".bubble"}, {31'd0, bus.bubble}, {31'd0, bb});
  endtask

  initial begin
    logic [3:0] esel;
    logic est, ebb, vld, mex, mmem, mwb, hz;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
    // reset holds outputs even with a live EX match; release is combinational
    #2 apply(mk(1, 5, 1, 0, 5, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0));
    #1 outs("reset", 4'b0001, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 chk("reset_release.sel", {28'd0, bus.fwd_sel}, 32'h2);
    chk_cnt("reset.cnt", 32'd0);
    rst_pulse();
    tbl[0]  = mk(1, 8, 1, 0, 8, 1, 0, 8, 1, 8, 0, 4'b0010, 0, 0);
    tbl[1]  = mk(1, 8, 0, 0, 8, 1, 0, 8, 1, 8, 0, 4'b0100, 0, 0);
    tbl[2]  = mk(1, 8, 0, 0, 8, 0, 0, 8, 1, 8, 0, 4'b1000, 0, 0);
    tbl[3]  = mk(1, 8, 0, 0, 8, 0, 0, 8, 0, 8, 0, 4'b0001, 0, 0);
    tbl[4]  = mk(1, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0, 4'b0001, 0, 0);
    tbl[5]  = mk(1, 3, 1, 0, 3, 1, 1, 3, 0, 0, 0, 4'b0010, 0, 0);
    tbl[6]  = mk(0, 7, 1, 1, 7, 1, 0, 7, 1, 7, 0, 4'b0001, 0, 0);
    tbl[7]  = mk(1, 9, 1, 1, 9, 0, 0, 0, 1, 9, 0, 4'b0001, 1, 1);
    tbl[8]  = mk(1, 4, 0, 0, 0, 1, 1, 4, 1, 4, 0, 4'b0001, 1, 1);
    tbl[9]  = mk(1, 9, 1, 1, 9, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 0);
    tbl[10] = mk(1, 6, 1, 1, 2, 0, 0, 0, 1, 6, 0, 4'b1000, 0, 0);
    tbl[11] = mk(1, 6, 0, 1, 6, 1, 0, 6, 1, 6, 0, 4'b0100, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i]);
      outs($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].st, tbl[i].bb);
      rst_pulse();
    end
    // EX load: two stall cycles then WB forward
    cyc(mk(1, 9, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    outs("lu2.c0", 4'b0001, 1, 1);
    cyc(mk(1, 9, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    outs("lu2.c1", 4'b0001, 1, 1);
    cyc(mk(1, 9, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0));
    outs("lu2.c2", 4'b1000, 0, 0);
    chk_cnt("lu2.cnt", 32'd2);
    rst_pulse();
    // MEM load: one stall cycle
    cyc(mk(1, 4, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0));
    outs("lu1.c0", 4'b0001, 1, 1);
    cyc(mk(1, 4, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0));
    outs("lu1.c1", 4'b1000, 0, 0);
    chk_cnt("lu1.cnt", 32'd1);
    rst_pulse();
    // freeze for three cycles while waiting
    cyc(mk(1, 9, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    outs("frz.c0", 4'b0001, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(mk(1, 9, 0, 0, 0, 1, 1, 9, 0, 0, 1, 0, 0, 0));
      outs($sformatf("frz.h%0d", i), 4'b0001, 1, 0);
      chk_cnt("frz.hcnt", 32'd1);
    end
    cyc(mk(1, 9, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    outs("frz.c1", 4'b0001, 1, 1);
    cyc(mk(1, 9, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0));
    outs("frz.c2", 4'b1000, 0, 0);
    chk_cnt("frz.cnt", 32'd2);
    rst_pulse();
    // async reset mid-wait
    cyc(mk(1, 9, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(1, 9, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    outs("arst.wait", 4'b0001, 1, 1);
    #1 rst_n = 1'b0;
    #1 outs("arst.low", 4'b0001, 0, 0);
    rst_pulse();
    // flush while waiting
    cyc(mk(1, 9, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 9, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0));
    outs("flush.c1", 4'b0001, 0, 0);
    cyc(mk(1, 9, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0));
    outs("flush.c2", 4'b1000, 0, 0);
    rst_pulse();
    // randomized against a remaining-stall-cycles model
    m_rem = 0;
    m_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      v = mk(($urandom % 4) != 0, 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 5'($urandom_range(0, 3)), ($urandom % 8) == 0, 0, 0, 0);
      vld = v.jr && v.rs != 0;
      mex = vld && v.exw && v.exd == v.rs;
      mmem = vld && v.mw && v.md == v.rs;
      mwb = vld && v.ww && v.wd == v.rs;
      hz = (mex && v.exl) || (!mex && mmem && v.ml);
      esel = 4'b0001;
      est = 1'b0;
      if (m_rem > 0) est = v.jr;
      else if (hz) est = 1'b1;
      else esel = mex ? 4'b0010 : mmem ? 4'b0100 : mwb ? 4'b1000 : 4'b0001;
      ebb = est && !v.fz;
      cyc(v);
      outs($sformatf("rnd%0d", i), esel, est, ebb);
      chk_cnt("rnd.cnt", m_cnt);
      if (!v.fz) begin
        if (est) m_cnt++;
        if (m_rem > 0) m_rem = v.jr ? m_rem - 1 : 0;
        else if (hz) m_rem = (mex && v.exl) ? 1 : 0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
